hm_tx_mrd: RTL and testbench
============================

HM_TX_MRD -- requirements
Module: hm_tx_mrd

Interface
REQ-001 SHALL have parameter MAX_RD_BYTES, default 128: maximum read request size in bytes; power of two, 64..4096.
REQ-002 SHALL have parameter TAG_WIDTH, default 5: width of the tag counter, 1..8; the tag is zero-extended into the 8-bit tag field.
REQ-003 SHALL have port trn_clk, input, 1: the single clock.
REQ-004 SHALL have port sys_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port tx_start, input, 1: one-cycle request strobe.
REQ-006 SHALL have port hm_addr, input, 64: start byte address; bits [1:0] ignored (DW-aligned).
REQ-007 SHALL have port hm_len, input, 16: total read length in DW.
REQ-008 SHALL have port req_id, input, 16: requester ID placed in the header.
REQ-009 SHALL have port tx_busy, output, 1: high from accepted tx_start until the tx_end cycle inclusive.
REQ-010 SHALL have port tx_end, output, 1: one-cycle pulse when the whole request is sent.
REQ-011 SHALL have ports trn_td (output, 64), trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n (outputs, 1 each), and trn_tdst_rdy_n (input, 1): TRN transmit interface.

Function
REQ-012 SHALL be an FSM with states IDLE, HDR0, HDR1 and DONE.
REQ-013 IDLE: tx_start=1 SHALL latch hm_addr, hm_len and req_id; next state SHALL be HDR0, or DONE if hm_len==0.
REQ-014 SHALL ignore tx_start in any state other than IDLE.
REQ-015 In HDR0/HDR1, trn_tsrc_rdy_n SHALL be 0; a beat transfers only on a cycle where trn_tsrc_rdy_n==0 and trn_tdst_rdy_n==0; trn_td/sof/eof/trem SHALL stay stable while trn_tdst_rdy_n==1.
REQ-016 HDR0 beat: trn_tsof_n=0, trn_teof_n=1, trn_trem_n=0, trn_td[63:32]={1'b0, fmt[1:0], 5'b00000, 14'b0, len[9:0]}, trn_td[31:0]={req_id, tag, lastBE, firstBE}.
REQ-017 firstBE SHALL be 4'hF; lastBE SHALL be 4'hF, or 4'h0 when the TLP length is 1 DW.
REQ-018 A 3DW header (fmt=00) SHALL be used when the current address [63:32] is 0; HDR1 then drives trn_td={addr[31:2],2'b00, 32'h0}, trn_trem_n=1, trn_tsof_n=1, trn_teof_n=0.
REQ-019 A 4DW header (fmt=01) SHALL be used otherwise; HDR1 then drives trn_td={addr[63:32], addr[31:2],2'b00}, trn_trem_n=0, trn_teof_n=0.
REQ-020 TLP length SHALL be min(remaining DW, (MAX_RD_BYTES - (addr mod MAX_RD_BYTES))/4), so no TLP crosses a MAX_RD_BYTES or 4 KB boundary.
REQ-021 A length of 1024 DW SHALL be encoded as 10'd0.
REQ-022 On the HDR1 transfer, address SHALL advance by length*4 (64-bit, wrap at 2^64), remaining SHALL decrease by length, and tag SHALL increment modulo 2^TAG_WIDTH.
REQ-023 After the HDR1 transfer, next state SHALL be HDR0 if remaining!=0 (no idle cycle between TLPs), else DONE.
REQ-024 DONE SHALL assert tx_end for exactly one cycle, then go to IDLE.
REQ-025 Tag SHALL persist across requests (not reset per request).
REQ-026 Outside HDR0/HDR1, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n and trn_trem_n SHALL be 1, and trn_td SHALL be 0.

Reset
REQ-027 sys_rst=1 SHALL immediately force IDLE, tag=0, tx_busy=0, tx_end=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_trem_n=1, trn_td=0.
REQ-028 A reset asserted mid-TLP SHALL abandon the TLP without tx_end; the first TLP after reset SHALL use tag 0.

Configuration
REQ-029 With macro HM_TX_MRD_64BIT_EN defined, REQ-018/REQ-019 SHALL apply as written.
REQ-030 Without HM_TX_MRD_64BIT_EN, hm_addr[63:32] SHALL be treated as 0, only 3DW headers SHALL be emitted, and address arithmetic SHALL be 32-bit.

Verification
REQ-031 addr 0x1000, len 8, tdst_rdy_n=0: one TLP -> beat0 td=0x00000008_{req_id}00FF, beat1 td=0x00001000_00000000 with trem_n=1; then tx_end pulse.
REQ-032 addr 0x1000000000000000, len 4 (macro defined) -> beat0 upper=0x20000004, beat1 td=0x10000000_00000000 with trem_n=0; without the macro -> 3DW header, beat1 upper=0x00000000.
REQ-033 addr 0x1070, len 40, MAX_RD_BYTES=128 -> three TLPs back-to-back: (0x1070, 4 DW, tag 0), (0x1080, 32 DW, tag 1), (0x1100, 4 DW, tag 2).
REQ-034 tdst_rdy_n held 1 for 9 cycles after tx_start, then 0 -> tsrc_rdy_n=0 and beat0 stable for all 9 cycles; beats transfer on consecutive cycles afterwards.
REQ-035 len 1 -> lastBE=0, trn_td[7:0]=0x0F; len 0 -> no TLP, tx_end on the cycle after tx_start.
REQ-036 sys_rst pulsed during HDR1 -> all outputs at reset values in the same cycle, no tx_end; the next request uses tag 0.

Source files
------------

// File: rtl/hm_tx_mrd.sv
// rtl/hm_tx_mrd.sv - host-memory read request (MRd TLP) generator on a TRN transmit port
//
// Splits one read request (hm_addr, hm_len DW) into MRd TLPs, none crossing a
// MAX_RD_BYTES boundary, and emits each as a two-beat 64-bit header.
//
// Parameters:
//   MAX_RD_BYTES  maximum read request size in bytes (power of two, 64..4096)
//   TAG_WIDTH     width of the tag counter (1..8), zero-extended into the tag field
// Build option:
//   HM_TX_MRD_64BIT_EN  when defined, addresses above 4 GB use 4DW headers;
//                       otherwise hm_addr[63:32] is ignored and only 3DW headers
//                       are produced with 32-bit address arithmetic.
// Ports:
//   trn_clk, sys_rst           clock, asynchronous active-high reset
//   tx_start                   one-cycle request strobe (accepted in IDLE only)
//   hm_addr, hm_len, req_id    request start address, length in DW, requester ID
//   tx_busy, tx_end            request in progress, one-cycle completion pulse
//   trn_td, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n, trn_tdst_rdy_n
//                              TRN transmit interface
module hm_tx_mrd #(
    parameter int MAX_RD_BYTES = 128,
    parameter int TAG_WIDTH    = 5
) (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        tx_start,
    input  logic [63:0] hm_addr,
    input  logic [15:0] hm_len,
    input  logic [15:0] req_id,
    output logic        tx_busy,
    output logic        tx_end,
    output logic [63:0] trn_td,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_trem_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    localparam int OFFW = $clog2(MAX_RD_BYTES);
`ifdef HM_TX_MRD_64BIT_EN
    localparam int AW = 64;
`else
    localparam int AW = 32;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [AW-1:0]          addr_q;     // current TLP address, always DW-aligned
    logic [15:0]            rem_q;      // DW still to request
    logic [15:0]            rid_q;
    logic [TAG_WIDTH-1:0]   tag_q;

    logic [31:0]            addr_hi;
    logic                   unused_addr_bits;
    logic [10:0]            avail_dw;
    logic [10:0]            tlp_len;
    logic                   four_dw;
    logic                   xfer;
    logic                   last_tlp;
    logic [3:0]             last_be;
    logic [1:0]             fmt;

`ifdef HM_TX_MRD_64BIT_EN
    assign addr_hi          = addr_q[63:32];
    assign unused_addr_bits = ^hm_addr[1:0];
`else
    assign addr_hi          = 32'h0;
    assign unused_addr_bits = ^{hm_addr[63:32], hm_addr[1:0]};
`endif

    // DW left before the next MAX_RD_BYTES boundary. Since MAX_RD_BYTES divides
    // 4 KB, this also keeps every TLP inside one 4 KB page.
    assign avail_dw = 11'(MAX_RD_BYTES / 4) - 11'(addr_q[OFFW-1:2]);
    assign tlp_len  = ({5'b0, avail_dw} > rem_q) ? rem_q[10:0] : avail_dw;
    assign four_dw  = (addr_hi != 32'h0);
    assign fmt      = four_dw ? 2'b01 : 2'b00;
    assign last_be  = (tlp_len == 11'd1) ? 4'h0 : 4'hF;
    assign xfer     = ~trn_tdst_rdy_n;
    assign last_tlp = (rem_q == {5'b0, tlp_len});

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tx_busy        = 1'b0;
        tx_end         = 1'b0;
        trn_td         = 64'h0;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_trem_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_nxt = (hm_len == 16'h0) ? DONE : HDR0;
                end
            end
            HDR0: begin
                tx_busy        = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_tsof_n     = 1'b0;
                trn_trem_n     = 1'b0;
                // A 1024 DW TLP encodes as length 0 by taking the low 10 bits.
                trn_td         = {1'b0, fmt, 5'b00000, 14'b0, tlp_len[9:0],
                                  rid_q, 8'(tag_q), last_be, 4'hF};
                if (xfer) begin
                    state_nxt = HDR1;
                end
            end
            HDR1: begin
                tx_busy        = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                // addr_q[1:0] is held at zero, so it forms the reserved bits directly.
                if (four_dw) begin
                    trn_td     = {addr_hi, addr_q[31:0]};
                    trn_trem_n = 1'b0;
                end else begin
                    trn_td     = {addr_q[31:0], 32'h0};
                    trn_trem_n = 1'b1;
                end
                if (xfer) begin
                    state_nxt = last_tlp ? DONE : HDR0;
                end
            end
            DONE: begin
                tx_busy   = 1'b1;
                tx_end    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request context. The tag is never cleared per request, only by reset.
    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr_q <= '0;
            rem_q  <= 16'h0;
            rid_q  <= 16'h0;
            tag_q  <= '0;
        end else begin
            if (state == IDLE && tx_start) begin
                addr_q <= {hm_addr[AW-1:2], 2'b00};
                rem_q  <= hm_len;
                rid_q  <= req_id;
            end else if (state == HDR1 && xfer) begin
                addr_q <= addr_q + AW'({tlp_len, 2'b00});
                rem_q  <= rem_q - {5'b0, tlp_len};
                tag_q  <= tag_q + TAG_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hm_tx_mrd.sv
// tb/tb_hm_tx_mrd.sv - self-checking bench for hm_tx_mrd (table vectors + beat scoreboard)
module tb_hm_tx_mrd;

    logic        trn_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [63:0] hm_addr = 64'h0;
    logic [15:0] hm_len = 16'h0;
    logic [15:0] req_id = 16'h0;
    logic        tx_busy;
    logic        tx_end;
    logic [63:0] trn_td;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_trem_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n = 1'b0;

    always #5 trn_clk = ~trn_clk;

    hm_tx_mrd #(.MAX_RD_BYTES(128), .TAG_WIDTH(5)) dut (
        .trn_clk        (trn_clk),
        .sys_rst        (sys_rst),
        .tx_start       (tx_start),
        .hm_addr        (hm_addr),
        .hm_len         (hm_len),
        .req_id         (req_id),
        .tx_busy        (tx_busy),
        .tx_end         (tx_end),
        .trn_td         (trn_td),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_trem_n     (trn_trem_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n (trn_tdst_rdy_n)
    );

    typedef struct {
        logic [63:0] td;
        logic        sof_n;
        logic        eof_n;
        logic        trem_n;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [15:0] len;
        logic [15:0] rid;
        int          stall;
        int          ntlp;
    } vec_t;

    beat_t      exp_q[$];
    beat_t      log_q[$];
    vec_t       vecs[8];
    int         total = 0;
    int         bad = 0;
    int         sof_cnt = 0;
    int         end_cnt = 0;
    logic [4:0] m_tag = 5'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: splits the request into TLPs and queues the expected beats.
    task automatic model_push(input logic [63:0] addr, input logic [15:0] len,
                              input logic [15:0] rid);
        logic [63:0] a;
        int          rem;
        int          off;
        int          maxdw;
        int          l;
        logic        four;
        beat_t       b;
        a = {addr[63:2], 2'b00};
`ifndef HM_TX_MRD_64BIT_EN
        a[63:32] = 32'h0;
`endif
        rem = int'(len);
        while (rem > 0) begin
            off   = int'(a % 64'd128);
            maxdw = (128 - off) / 4;
            l     = (rem < maxdw) ? rem : maxdw;
            four  = (a[63:32] != 32'h0);
            b.td     = {1'b0, (four ? 2'b01 : 2'b00), 5'b0, 14'b0, 10'(l), rid,
                        3'b000, m_tag, ((l == 1) ? 4'h0 : 4'hF), 4'hF};
            b.sof_n  = 1'b0;
            b.eof_n  = 1'b1;
            b.trem_n = 1'b0;
            exp_q.push_back(b);
            if (four) begin
                b.td     = a;
                b.trem_n = 1'b0;
            end else begin
                b.td     = {a[31:0], 32'h0};
                b.trem_n = 1'b1;
            end
            b.sof_n = 1'b1;
            b.eof_n = 1'b0;
            exp_q.push_back(b);
            a = a + 64'(l * 4);
`ifndef HM_TX_MRD_64BIT_EN
            a[63:32] = 32'h0;
`endif
            rem   = rem - l;
            m_tag = m_tag + 5'd1;
        end
    endtask

    // Beat monitor / scoreboard.
    always @(negedge trn_clk) begin
        beat_t got;
        beat_t e;
        if (!sys_rst && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            got.td     = trn_td;
            got.sof_n  = trn_tsof_n;
            got.eof_n  = trn_teof_n;
            got.trem_n = trn_trem_n;
            log_q.push_back(got);
            if (!got.sof_n) sof_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got td %h expected no beat", trn_td);
            end else begin
                e = exp_q.pop_front();
                check("beat_td", got.td, e.td);
                check("beat_sof_eof_rem", {61'b0, got.sof_n, got.eof_n, got.trem_n},
                      {61'b0, e.sof_n, e.eof_n, e.trem_n});
            end
        end
        if (tx_end) end_cnt++;
    end

    task automatic run_req(input string name, input logic [63:0] addr, input logic [15:0] len,
                           input logic [15:0] rid, input int stall, input int exp_n);
        int   base_sof;
        int   waited;
        logic got_end;
        model_push(addr, len, rid);
        base_sof = sof_cnt;
        @(posedge trn_clk); #1;
        hm_addr        = addr;
        hm_len         = len;
        req_id         = rid;
        tx_start       = 1'b1;
        trn_tdst_rdy_n = (stall > 0);
        @(posedge trn_clk); #1;
        tx_start = 1'b0;
        hm_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        hm_len   = 16'hFFFF;
        for (int i = 0; i < stall; i++) begin
            @(negedge trn_clk);
            check({name, ":stall_src_rdy_n"}, {63'b0, trn_tsrc_rdy_n}, 64'd0);
            check({name, ":stall_td"}, trn_td, exp_q[0].td);
            check({name, ":stall_sof_n"}, {63'b0, trn_tsof_n}, 64'd0);
            @(posedge trn_clk); #1;
        end
        trn_tdst_rdy_n = 1'b0;
        got_end = 1'b0;
        for (waited = 0; waited < 3000; waited++) begin
            @(negedge trn_clk);
            if (tx_end) begin
                got_end = 1'b1;
                break;
            end
        end
        check({name, ":tx_end_seen"}, {63'b0, got_end}, 64'd1);
        check({name, ":cycles_to_end"}, 64'(waited), 64'(2 * exp_n));
        check({name, ":busy_at_end"}, {63'b0, tx_busy}, 64'd1);
        check({name, ":tlp_count"}, 64'(sof_cnt - base_sof), 64'(exp_n));
        check({name, ":queue_drained"}, 64'(exp_q.size()), 64'd0);
        @(negedge trn_clk);
        check({name, ":end_pulse_width"}, {63'b0, tx_end}, 64'd0);
        check({name, ":busy_after"}, {63'b0, tx_busy}, 64'd0);
    endtask

    initial begin
        int idx;
        int e_before;

        vecs[0] = '{addr: 64'h0000_0000_0000_2000, len: 16'd16,  rid: 16'h0102, stall: 0, ntlp: 1};
        vecs[1] = '{addr: 64'h0000_0000_0000_1070, len: 16'd40,  rid: 16'h0304, stall: 0, ntlp: 3};
        vecs[2] = '{addr: 64'h0000_0000_0000_3003, len: 16'd2,   rid: 16'h0506, stall: 0, ntlp: 1};
        vecs[3] = '{addr: 64'h0000_0000_0000_3000, len: 16'd0,   rid: 16'h0708, stall: 0, ntlp: 0};
        vecs[4] = '{addr: 64'h0000_0000_0000_4000, len: 16'd9,   rid: 16'h090A, stall: 9, ntlp: 1};
        vecs[5] = '{addr: 64'h0000_0000_FFFF_FFC0, len: 16'd64,  rid: 16'h0B0C, stall: 0, ntlp: 3};
        vecs[6] = '{addr: 64'h0000_0000_0000_5004, len: 16'd300, rid: 16'h0D0E, stall: 2, ntlp: 10};
        vecs[7] = '{addr: 64'h0000_0000_0000_0000, len: 16'd512, rid: 16'h0F10, stall: 0, ntlp: 16};

        // Reset state.
        #1;
        check("rst_ctl", {58'b0, tx_busy, tx_end, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n},
              64'h0F);
        check("rst_td", trn_td, 64'h0);
        repeat (2) @(posedge trn_clk);
        #1 sys_rst = 1'b0;

        // Basic 3DW request with literal header values.
        idx = log_q.size();
        run_req("basic", 64'h1000, 16'd8, 16'hABCD, 0, 1);
        check("basic:hdr0", log_q[idx].td, 64'h00000008_ABCD00FF);
        check("basic:hdr1", log_q[idx+1].td, 64'h00001000_00000000);
        check("basic:hdr1_rem", {63'b0, log_q[idx+1].trem_n}, 64'd1);

        for (int v = 0; v < 8; v++) begin
            run_req($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].rid,
                    vecs[v].stall, vecs[v].ntlp);
        end

        // High address: 4DW header only with the 64-bit option.
        idx = log_q.size();
        run_req("hiaddr", 64'h1000_0000_0000_0000, 16'd4, 16'h1111, 0, 1);
`ifdef HM_TX_MRD_64BIT_EN
        check("hiaddr:hdr0_upper", {32'b0, log_q[idx].td[63:32]}, 64'h20000004);
        check("hiaddr:hdr1", log_q[idx+1].td, 64'h10000000_00000000);
        check("hiaddr:hdr1_rem", {63'b0, log_q[idx+1].trem_n}, 64'd0);
`else
        check("hiaddr:hdr0_upper", {32'b0, log_q[idx].td[63:32]}, 64'h00000004);
        check("hiaddr:hdr1_upper", {32'b0, log_q[idx+1].td[63:32]}, 64'h0);
        check("hiaddr:hdr1_rem", {63'b0, log_q[idx+1].trem_n}, 64'd1);
`endif

        // Single-DW request: last byte enables zero.
        idx = log_q.size();
        run_req("len1", 64'h8000, 16'd1, 16'h2222, 0, 1);
        check("len1:be", {56'b0, log_q[idx].td[7:0]}, 64'h0F);

        // Reset during HDR1 abandons the TLP; tag restarts at 0.
        model_push(64'h6000, 16'd8, 16'h7777);
        @(posedge trn_clk); #1;
        hm_addr  = 64'h6000;
        hm_len   = 16'd8;
        req_id   = 16'h7777;
        tx_start = 1'b1;
        @(posedge trn_clk); #1;
        tx_start = 1'b0;
        @(posedge trn_clk); #1;
        check("midrst:in_hdr1", {63'b0, trn_teof_n}, 64'd0);
        e_before = end_cnt;
        sys_rst = 1'b1;
        #1;
        check("midrst:ctl", {58'b0, tx_busy, tx_end, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n,
              trn_trem_n}, 64'h0F);
        check("midrst:td", trn_td, 64'h0);
        @(posedge trn_clk); #1;
        sys_rst = 1'b0;
        exp_q.delete();
        m_tag = 5'd0;
        repeat (3) @(negedge trn_clk);
        check("midrst:no_tx_end", 64'(end_cnt), 64'(e_before));
        idx = log_q.size();
        run_req("after_rst", 64'h1000, 16'd8, 16'hBEEF, 0, 1);
        check("after_rst:tag0", log_q[idx].td, 64'h00000008_BEEF00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
